// File: rtl/sobel_edge_conv.sv
// Sobel edge detector: one 3x3 window per valid cycle in, one thresholded edge
// pixel out three cycles later, plus a per-line completion pulse.
module sobel_edge_conv #(
    parameter int unsigned THRESHOLD  = 4000,
    parameter int unsigned LINE_WIDTH = 512,
    parameter logic [7:0]  EDGE_VAL   = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESETH,
    input  logic [71:0] PIXEL_DATA,
    input  logic        PIXEL_DATA_VALID,
    output logic [7:0]  EDGE_PIXEL,
    output logic        EDGE_PIXEL_VALID,
    output logic        LINE_DONE
);

    localparam int unsigned      CNT_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WIDTH - 1);
    localparam logic [20:0]      THRESH   = 21'(THRESHOLD);

    logic [7:0] w_p [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_unpack
            assign w_p[gi] = PIXEL_DATA[8*gi +: 8];
        end
    endgenerate

    // Each weighted column/row sum peaks at 1020, so 10 bits unsigned suffice.
    logic [9:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [10:0] w_gx, w_gy;

    assign w_gx_pos = 10'(w_p[2]) + {1'b0, w_p[5], 1'b0} + 10'(w_p[8]);
    assign w_gx_neg = 10'(w_p[0]) + {1'b0, w_p[3], 1'b0} + 10'(w_p[6]);
    assign w_gy_pos = 10'(w_p[6]) + {1'b0, w_p[7], 1'b0} + 10'(w_p[8]);
    assign w_gy_neg = 10'(w_p[0]) + {1'b0, w_p[1], 1'b0} + 10'(w_p[2]);
    assign w_gx     = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
    assign w_gy     = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});

    logic [2:0]         r_vld_sr;
    logic signed [10:0] r_gx, r_gy;
    logic [19:0]        r_gx_sq, r_gy_sq;
    logic [7:0]         r_edge_pixel;
    logic               r_line_done;
    logic [CNT_W-1:0]   r_line_cnt;

    // Squaring the magnitude avoids a signed multiplier; |G| <= 1020 fits 10 bits.
    logic [9:0]  w_gx_mag, w_gy_mag;
    logic [20:0] w_sum;

    assign w_gx_mag = r_gx[10] ? 10'(-r_gx) : 10'(r_gx);
    assign w_gy_mag = r_gy[10] ? 10'(-r_gy) : 10'(r_gy);
    assign w_sum    = {1'b0, r_gx_sq} + {1'b0, r_gy_sq};

    // Intermediate data stages carry no reset; their valid bits gate everything.
    always_ff @(posedge CLK) begin
        if (PIXEL_DATA_VALID) begin
            r_gx <= w_gx;
            r_gy <= w_gy;
        end
        if (r_vld_sr[0]) begin
            r_gx_sq <= 20'(w_gx_mag) * 20'(w_gx_mag);
            r_gy_sq <= 20'(w_gy_mag) * 20'(w_gy_mag);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETH) begin
            r_vld_sr     <= '0;
            r_edge_pixel <= '0;
            r_line_done  <= 1'b0;
            r_line_cnt   <= '0;
        end else begin
            r_vld_sr    <= {r_vld_sr[1:0], PIXEL_DATA_VALID};
            r_line_done <= 1'b0;
            if (r_vld_sr[1]) begin
                r_edge_pixel <= (w_sum > THRESH) ? EDGE_VAL : 8'h00;
                if (r_line_cnt == CNT_LAST) begin
                    r_line_cnt  <= '0;
                    r_line_done <= 1'b1;
                end else begin
                    r_line_cnt <= r_line_cnt + 1'b1;
                end
            end
        end
    end

    assign EDGE_PIXEL       = r_edge_pixel;
    assign EDGE_PIXEL_VALID = r_vld_sr[2];
    assign LINE_DONE        = r_line_done;

endmodule

// File: tb/tb_sobel_edge_conv.sv
// Self-checking bench for sobel_edge_conv: directed windows, randomized streams
// with valid gaps against an arithmetic reference, and mid-pipeline reset.
module tb_sobel_edge_conv;

    logic        CLK = 1'b0;
    logic        RESETH;
    logic [71:0] PIXEL_DATA;
    logic        PIXEL_DATA_VALID;
    logic [7:0]  EDGE_PIXEL;
    logic        EDGE_PIXEL_VALID;
    logic        LINE_DONE;

    always #5 CLK = ~CLK;

    sobel_edge_conv dut (
        .CLK              (CLK),
        .RESETH           (RESETH),
        .PIXEL_DATA       (PIXEL_DATA),
        .PIXEL_DATA_VALID (PIXEL_DATA_VALID),
        .EDGE_PIXEL       (EDGE_PIXEL),
        .EDGE_PIXEL_VALID (EDGE_PIXEL_VALID),
        .LINE_DONE        (LINE_DONE)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic       obs_v, obs_ld;
    logic [7:0] obs_px;

    typedef struct packed {
        logic       v;
        logic [7:0] px;
    } exp_t;

    function automatic logic [71:0] win(input logic [7:0] a0, a1, a2, a3, a4,
                                        input logic [7:0] a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Sobel magnitude squared straight from the kernel definition.
    function automatic int ref_mag(input logic [71:0] w);
        int p [9];
        int gx, gy;
        for (int k = 0; k < 9; k++) p[k] = int'(w[8*k +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        return gx*gx + gy*gy;
    endfunction

    function automatic logic [7:0] ref_edge(input logic [71:0] w);
        return (ref_mag(w) > 4000) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        int base;
        base = $urandom_range(0, 240);
        for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 1) == 0) w[8*k +: 8] = 8'($urandom_range(0, 255));
            else                           w[8*k +: 8] = 8'(base + $urandom_range(0, 12));
        end
        return w;
    endfunction

    // One clock: sample outputs left by the previous edge, then drive new inputs.
    task automatic step_cycle(input logic v, input logic [71:0] d);
        @(negedge CLK);
        obs_v  = EDGE_PIXEL_VALID;
        obs_px = EDGE_PIXEL;
        obs_ld = LINE_DONE;
        PIXEL_DATA_VALID = v;
        PIXEL_DATA       = d;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETH = 1'b1;
        PIXEL_DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESETH = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESETH = 1'b1;
        PIXEL_DATA_VALID = 1'b1;
        PIXEL_DATA = win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        repeat (4) @(negedge CLK);
        n_checks++;
        if (EDGE_PIXEL_VALID !== 1'b0 || LINE_DONE !== 1'b0 || EDGE_PIXEL !== 8'h00) begin
            n_fails++;
            $display("FAIL reset_state: valid=%b done=%b pixel=%h, required 0/0/00",
                     EDGE_PIXEL_VALID, LINE_DONE, EDGE_PIXEL);
        end
        RESETH = 1'b0;
        PIXEL_DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_cycle(1'b0, '0);
            n_checks++;
            if (obs_v !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_no_output: cycle %0d valid=%b, required 0", i, obs_v);
            end
        end
        $display("test_reset: outputs idle through and after reset");
    endtask

    // Covers uniform, vertical edge, both threshold sides and negative gradient.
    task automatic test_directed();
        logic [71:0] wins [5];
        string       names [5];
        logic [7:0]  exp_px;
        logic        early;
        wins[0] = {9{8'h80}};                               names[0] = "uniform";
        wins[1] = win(0, 255, 255, 0, 255, 255, 0, 255, 255); names[1] = "vertical";
        wins[2] = win(0, 0, 10, 0, 0, 10, 0, 0, 10);        names[2] = "thresh_below";
        wins[3] = win(0, 0, 16, 0, 0, 16, 0, 0, 16);        names[3] = "thresh_above";
        wins[4] = win(255, 255, 255, 0, 0, 0, 0, 0, 0);     names[4] = "negative_gy";
        for (int t = 0; t < 5; t++) begin
            exp_px = ref_edge(wins[t]);
            step_cycle(1'b1, wins[t]);
            step_cycle(1'b0, '0);
            early = obs_v;
            step_cycle(1'b0, '0);
            early = early | obs_v;
            n_checks++;
            if (early !== 1'b0) begin
                n_fails++;
                $display("FAIL %s_latency_early: valid seen before +3, required none", names[t]);
            end
            step_cycle(1'b0, '0);
            n_checks++;
            if (obs_v !== 1'b1 || obs_px !== exp_px) begin
                n_fails++;
                $display("FAIL %s_output: valid=%b pixel=%h, required 1/%h",
                         names[t], obs_v, obs_px, exp_px);
            end
            step_cycle(1'b0, '0);
            n_checks++;
            if (obs_v !== 1'b0 || obs_px !== exp_px) begin
                n_fails++;
                $display("FAIL %s_hold: valid=%b pixel=%h, required 0/%h",
                         names[t], obs_v, obs_px, exp_px);
            end
            $display("test_directed %s: mag2=%0d pixel=%h", names[t], ref_mag(wins[t]), obs_px);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        q [$];
        exp_t        e;
        logic [71:0] d;
        logic        v, prev_gap, exp_ld;
        logic [7:0]  mdl_px;
        int          sent, drain, mdl_cnt, n_out, n_ld;
        int          ld_at [$];
        do_reset();
        mdl_px = 8'h00; mdl_cnt = 0; n_out = 0; n_ld = 0;
        sent = 0; drain = 0; prev_gap = 1'b0;
        for (int k = 0; k < 3; k++) q.push_back('{v: 1'b0, px: 8'h00});
        while (drain < 4) begin
            if (sent < 1024) begin
                v = prev_gap ? 1'b1 : ($urandom_range(0, 7) != 0);
                prev_gap = ~v;
            end else begin
                v = 1'b0;
                drain++;
            end
            d = rand_win();
            if (v) sent++;
            step_cycle(v, d);
            q.push_back('{v: v, px: ref_edge(d)});
            e = q.pop_front();
            exp_ld = 1'b0;
            if (e.v) begin
                n_out++;
                mdl_px = e.px;
                exp_ld = (mdl_cnt == 511);
                mdl_cnt = exp_ld ? 0 : mdl_cnt + 1;
            end
            n_checks++;
            if (obs_v !== e.v || obs_px !== mdl_px || obs_ld !== exp_ld) begin
                n_fails++;
                $display("FAIL stream_out: out#%0d valid=%b pixel=%h done=%b, required %b/%h/%b",
                         n_out, obs_v, obs_px, obs_ld, e.v, mdl_px, exp_ld);
            end
            if (obs_ld === 1'b1) begin
                n_ld++;
                ld_at.push_back(n_out);
                $display("test_back_to_back: LINE_DONE at output %0d", n_out);
            end
        end
        n_checks++;
        if (n_ld != 2 || ld_at.size() != 2 || n_out != 1024) begin
            n_fails++;
            $display("FAIL line_done_count: pulses=%0d outputs=%0d, required 2/1024", n_ld, n_out);
        end else begin
            n_checks++;
            if (ld_at[0] != 512 || ld_at[1] != 1024) begin
                n_fails++;
                $display("FAIL line_done_position: at %0d,%0d, required 512,1024", ld_at[0], ld_at[1]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int n_out, n_ld;
        do_reset();
        for (int i = 0; i < 300; i++) step_cycle(1'b1, rand_win());
        step_cycle(1'b1, win(0, 255, 255, 0, 255, 255, 0, 255, 255));
        step_cycle(1'b1, win(255, 255, 255, 0, 0, 0, 0, 0, 0));
        step_cycle(1'b0, '0);
        RESETH = 1'b1;
        @(negedge CLK);
        RESETH = 1'b0;
        n_checks++;
        if (EDGE_PIXEL_VALID !== 1'b0 || EDGE_PIXEL !== 8'h00 || LINE_DONE !== 1'b0) begin
            n_fails++;
            $display("FAIL midflight_reset_state: valid=%b pixel=%h done=%b, required 0/00/0",
                     EDGE_PIXEL_VALID, EDGE_PIXEL, LINE_DONE);
        end
        for (int i = 0; i < 4; i++) begin
            step_cycle(1'b0, '0);
            n_checks++;
            if (obs_v !== 1'b0) begin
                n_fails++;
                $display("FAIL midflight_dropped: cycle %0d valid=%b, required 0", i, obs_v);
            end
        end
        n_out = 0; n_ld = 0;
        for (int i = 0; i < 512 + 4; i++) begin
            step_cycle(i < 512, rand_win());
            if (obs_v === 1'b1) n_out++;
            if (obs_ld === 1'b1) n_ld++;
            n_checks++;
            if (obs_ld !== (obs_v === 1'b1 && n_out == 512)) begin
                n_fails++;
                $display("FAIL midflight_line_done: output %0d done=%b, required %b",
                         n_out, obs_ld, (obs_v === 1'b1 && n_out == 512));
            end
        end
        n_checks++;
        if (n_out != 512 || n_ld != 1) begin
            n_fails++;
            $display("FAIL midflight_totals: outputs=%0d pulses=%0d, required 512/1", n_out, n_ld);
        end
        $display("test_reset_midflight: %0d outputs, %0d LINE_DONE after reset", n_out, n_ld);
    endtask

    initial begin
        RESETH = 1'b1;
        PIXEL_DATA_VALID = 1'b0;
        PIXEL_DATA = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
